ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port feature/weight BRAM among NUM_REQ masters: host loader, conv controller, FC controller.
//  Round-robin grant with per-requester lock, so the conv controller keeps the port for a full 5x5 window burst.
//  Muxes address/write data to the RAM and routes read data back with a one-hot rvalid tag.
// PARAMETERS
//  DATA_WIDTH   8    RAM word width
//  ADDR_WIDTH   10   RAM address width (covers image region 0..783, weights from 800)
//  NUM_REQ      3    number of requesters (index 0 = host, 1 = conv, 2 = fc)
//  RAM_LATENCY  1    RAM read latency in cycles, 1..4
//  MAX_LOCK     32   consecutive locked grants before forced release (ARB_LOCK_TIMEOUT_EN only)
// PORTS
//  clk           in   1                    single clock, rising edge
//  rst_n         in   1                    asynchronous, active-low reset
//  req           in   NUM_REQ              per-requester access request
//  req_lock      in   NUM_REQ              hold ownership after current access
//  req_we        in   NUM_REQ              1 = write, 0 = read
//  req_addr      in   NUM_REQ*ADDR_WIDTH   flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata     in   NUM_REQ*DATA_WIDTH   flattened write data
//  gnt           out  NUM_REQ              one-hot (or 0): access of requester i is issued this cycle
//  rvalid        out  NUM_REQ              one-hot: rdata belongs to requester i this cycle
//  rdata         out  DATA_WIDTH           read data, broadcast to all requesters
//  ram_en        out  1                    RAM enable
//  ram_we        out  1                    RAM write enable
//  ram_addr      out  ADDR_WIDTH           RAM address
//  ram_wdata     out  DATA_WIDTH           RAM write data
//  ram_rdata     in   DATA_WIDTH           RAM read data, valid RAM_LATENCY cycles after ram_en & !ram_we
//  lock_timeout  out  1                    1-cycle pulse on forced lock release (tied 0 without the macro)
// BEHAVIOUR
//  - State: owner_vld, owner[$clog2(NUM_REQ)], rr_ptr (last granted index), lock_cnt.
//  - FSM IDLE (owner_vld=0) / OWN (owner_vld=1).
//  - Combinational: gnt[i] = owner_vld & owner==i & req[i]. ram_en = |gnt. ram_we/addr/wdata are the owner's fields, else 0.
//  - IDLE: any req -> owner <= first requester after rr_ptr (wrapping), go OWN. Grant appears the next cycle (1 bubble).
//  - OWN, req[owner] & req_lock[owner]: stay, owner unchanged.
//  - OWN, req[owner] & !req_lock[owner]: access issues; at the edge rr_ptr <= owner and re-arbitrate.
//    Other requesters win round-robin; the same owner is kept only if it is the sole requester (no bubble).
//  - OWN, !req[owner]: no access; at the edge re-arbitrate, or go IDLE if req==0. Handover costs 1 bubble.
//  - Lock is only sampled while req[owner]=1. Dropping req ends ownership regardless of lock.
//  - Read return: shift pipe of RAM_LATENCY stages carrying {valid, owner}, loaded with ram_en & !ram_we.
//    rvalid = onehot(tail) & tail.valid. rdata = ram_rdata (not registered).
//  - Writes produce no rvalid. Back-to-back reads give one rvalid per cycle, in order.
//  - Simultaneous req from all masters with rr_ptr=2: order 0,1,2,0...
//  - Reset mid-burst: all state cleared asynchronously, in-flight reads dropped (rvalid 0).
//  - Reset values: gnt=0, rvalid=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, lock_timeout=0,
//    owner_vld=0, rr_ptr=NUM_REQ-1 (requester 0 wins first).
// CONFIGURATION
//  ARB_LOCK_TIMEOUT_EN defined:
//    - lock_cnt counts consecutive granted cycles of one owner; it is cleared on owner change.
//    - On the MAX_LOCK-th granted cycle the lock is ignored: re-arbitrate, pulse lock_timeout.
//  ARB_LOCK_TIMEOUT_EN undefined:
//    - A lock is held indefinitely; lock_cnt is not built; lock_timeout = 0.
// STRUCTURE
//  - Shared package/header lenet_pkg: DATA_WIDTH, ADDR_WIDTH, IMG_START_ADDR=0, IMG_DATA_COUNT=784,
//    WEIGHT_START_ADDR=800, requester IDs REQ_HOST=0, REQ_CONV=1, REQ_FC=2.
//  - One sub-module rr_priority_pick: combinational (req, rr_ptr) -> (any, idx), first set bit after rr_ptr, wrapping.
// TESTING
//  1. Reset, then req=3'b010 read addr 800 -> gnt=010 one cycle after req.
//     rvalid=010 one cycle later, rdata = RAM[800].
//  2. req=3'b111 unlocked, held -> gnt sequence 001,010,100,001; rvalid follows each by RAM_LATENCY.
//  3. Conv holds req_lock for 25 reads (addr 0..24) while host requests -> host gets no gnt until conv drops lock.
//     Host is then granted next.
//  4. Host write addr 5 data 8'hA5, then conv read addr 5 -> ram_we=1 once, conv later sees rdata=8'hA5.
//     No rvalid is produced for the write.
//  5. rst_n low while conv burst and two reads in flight -> all outputs 0 immediately, no rvalid after release.
//  6. ARB_LOCK_TIMEOUT_EN, MAX_LOCK=4, conv locked, fc requesting.
//     -> 4 conv grants, lock_timeout pulse, next grant to fc. Without the macro conv keeps the port.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet accelerator memory subsystem.
// Requester IDs index the ram_port_arbiter request vectors.
package lenet_pkg;
    localparam int DATA_WIDTH        = 8;
    localparam int ADDR_WIDTH        = 10;
    localparam int NUM_REQ           = 3;
    localparam int IMG_START_ADDR    = 0;
    localparam int IMG_DATA_COUNT    = 784;
    localparam int WEIGHT_START_ADDR = 800;
    localparam int REQ_HOST          = 0;
    localparam int REQ_CONV          = 1;
    localparam int REQ_FC            = 2;

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } arb_state_e;
endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request after ptr, wrapping around.
// Purely combinational; the requester at ptr itself has lowest priority.
module rr_priority_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);
    import lenet_pkg::*;

    function automatic int wrap_idx(input int p, input int off);
        int s;
        s = p + off;
        return (s >= N) ? s - N : s;
    endfunction

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int off = N; off >= 1; off--) begin
            if (req[wrap_idx(int'(ptr), off)]) begin
                any = 1'b1;
                idx = IW'(wrap_idx(int'(ptr), off));
            end
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with per-requester lock for the shared feature/weight BRAM.
// Define ARB_LOCK_TIMEOUT_EN to force lock release after MAX_LOCK granted cycles.
module ram_port_arbiter #(
    parameter int DATA_WIDTH  = lenet_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = lenet_pkg::ADDR_WIDTH,
    parameter int NUM_REQ     = lenet_pkg::NUM_REQ,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_LOCK    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic [DATA_WIDTH-1:0]         ram_rdata,
    output logic                          lock_timeout
);
    import lenet_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    arb_state_e    state;
    logic [IW-1:0] owner;
    logic [IW-1:0] rr_ptr;
    logic          own_req;
    logic          force_rel;
    logic          keep;
    logic [IW-1:0] arb_ptr;
    logic          pick_any;
    logic [IW-1:0] pick_idx;

    assign own_req = (state == ST_OWN) && req[owner];

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(MAX_LOCK - 1);
    logic [CW-1:0] lock_cnt;

    assign force_rel = own_req && req_lock[owner] && (lock_cnt == CNT_TOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            lock_timeout <= force_rel;
            if (force_rel || !own_req || (!keep && pick_idx != owner))
                lock_cnt <= '0;
            else if (lock_cnt != CNT_TOP)
                lock_cnt <= lock_cnt + 1'b1;
        end
    end
`else
    assign force_rel    = 1'b0;
    assign lock_timeout = 1'b0;
`endif

    assign keep    = own_req && req_lock[owner] && !force_rel;
    // An issued access rotates priority past the current owner.
    assign arb_ptr = own_req ? owner : rr_ptr;

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (arb_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            owner  <= '0;
            rr_ptr <= LAST;
        end else if (!keep) begin
            if (own_req)
                rr_ptr <= owner;
            if (pick_any) begin
                state <= ST_OWN;
                owner <= pick_idx;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    always_comb begin
        gnt       = '0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (own_req) begin
            gnt[owner] = 1'b1;
            ram_en     = 1'b1;
            ram_we     = req_we[owner];
            ram_addr   = req_addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
            ram_wdata  = req_wdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Read-return tag pipe, matched to the RAM read latency.
    logic [RAM_LATENCY-1:0] pipe_vld;
    logic [IW-1:0]          pipe_id [RAM_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RAM_LATENCY; i++)
                pipe_id[i] <= '0;
        end else begin
            pipe_vld[0] <= ram_en && !ram_we;
            pipe_id[0]  <= owner;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        if (pipe_vld[RAM_LATENCY-1])
            rvalid[pipe_id[RAM_LATENCY-1]] = 1'b1;
    end

    assign rdata = ram_rdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a 1-cycle RAM model.
// Lock-timeout expectations follow ARB_LOCK_TIMEOUT_EN.
module tb_ram_port_arbiter;
    localparam int DW  = 8;
    localparam int AW  = 10;
    localparam int NR  = 3;
    localparam int LAT = 1;
    localparam int ML  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req, req_lock, req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    gnt, rvalid;
    logic [DW-1:0]    rdata, ram_wdata, ram_rdata;
    logic             ram_en, ram_we, lock_timeout;
    logic [AW-1:0]    ram_addr;

    logic [DW-1:0] mem [1024];
    logic [1023:0] written = '0;
    int n_cmp  = 0;
    int n_fail = 0;

    ram_port_arbiter #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_REQ (NR),
        .RAM_LATENCY (LAT), .MAX_LOCK (ML)
    ) dut (
        .clk (clk), .rst_n (rst_n), .req (req), .req_lock (req_lock),
        .req_we (req_we), .req_addr (req_addr), .req_wdata (req_wdata),
        .gnt (gnt), .rvalid (rvalid), .rdata (rdata), .ram_en (ram_en),
        .ram_we (ram_we), .ram_addr (ram_addr), .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata), .lock_timeout (lock_timeout)
    );

    always #5 clk = ~clk;

    // Unwritten words read back as (addr low byte) ^ 8'h3C.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= written[ram_addr] ? mem[ram_addr]
                                               : (ram_addr[7:0] ^ 8'h3C);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic on, input logic lk,
                         input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        req[id]               = on;
        req_lock[id]          = lk;
        req_we[id]            = we;
        req_addr[id*AW +: AW] = a;
        req_wdata[id*DW +: DW] = d;
    endtask

    task automatic idle_all();
        req = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        req   = 3'b111;
        #1;
        n_cmp++;
        if (gnt !== 3'b000) begin
            n_fail++; $display("FAIL rst_gnt: got %b want 000", gnt);
        end
        n_cmp++;
        if ({rvalid, ram_en, ram_we, lock_timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_ctl: got %b want 000000",
                     {rvalid, ram_en, ram_we, lock_timeout});
        end
        tick();
        n_cmp++;
        if ({ram_addr, ram_wdata, gnt} !== '0) begin
            n_fail++;
            $display("FAIL rst_bus: got addr %h wdata %h gnt %b want 0",
                     ram_addr, ram_wdata, gnt);
        end
        idle_all();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        drive(1, 1, 0, 0, 10'd800, 8'h00);
        #1;
        n_cmp++;
        if (gnt !== 3'b000) begin
            n_fail++; $display("FAIL t1_bubble: got %b want 000", gnt);
        end
        tick();
        n_cmp++;
        if (gnt !== 3'b010 || ram_addr !== 10'd800 || ram_en !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_gnt: got gnt %b addr %0d want 010 addr 800",
                     gnt, ram_addr);
        end
        tick();
        idle_all();
        #1;
        n_cmp++;
        if (rvalid !== 3'b010 || rdata !== 8'h1C) begin
            n_fail++;
            $display("FAIL t1_rdata: got rvalid %b rdata %h want 010 1c",
                     rvalid, rdata);
        end
        tick();
        n_cmp++;
        if (rvalid !== 3'b000) begin
            n_fail++; $display("FAIL t1_rv_end: got %b want 000", rvalid);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] eg [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
        logic [2:0] ev [6] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
        logic [7:0] ed [6] = '{8'h00, 8'h00, 8'h36, 8'h28, 8'h22, 8'h36};
        do_reset();
        drive(0, 1, 0, 0, 10'd10, 8'h00);
        drive(1, 1, 0, 0, 10'd20, 8'h00);
        drive(2, 1, 0, 0, 10'd30, 8'h00);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            if (c == 5) idle_all();
            #1;
            n_cmp++;
            if (gnt !== eg[c] || rvalid !== ev[c]) begin
                n_fail++;
                $display("FAIL t2_rr c%0d: got gnt %b rv %b want %b %b",
                         c, gnt, rvalid, eg[c], ev[c]);
            end
            if (ev[c] != 3'b000) begin
                n_cmp++;
                if (rdata !== ed[c]) begin
                    n_fail++;
                    $display("FAIL t2_rdata c%0d: got %h want %h", c, rdata, ed[c]);
                end
            end
        end
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        drive(1, 1, 1, 0, 10'd0, 8'h00);
        #1;
        n_cmp++;
        if (gnt !== 3'b000) begin
            n_fail++; $display("FAIL t3_bubble: got %b want 000", gnt);
        end
        for (int k = 0; k < 25; k++) begin
            tick();
            drive(1, 1, (k < 24), 0, AW'(k), 8'h00);
            if (k == 0) drive(0, 1, 0, 0, 10'd7, 8'h00);
            #1;
            n_cmp++;
            if (gnt !== 3'b010) begin
                n_fail++; $display("FAIL t3_lock k%0d: got %b want 010", k, gnt);
            end
            if (k > 0) begin
                n_cmp++;
                if (rvalid !== 3'b010 || rdata !== (8'(k - 1) ^ 8'h3C)) begin
                    n_fail++;
                    $display("FAIL t3_rd k%0d: got rv %b rdata %h want 010 %h",
                             k, rvalid, rdata, 8'(k - 1) ^ 8'h3C);
                end
            end
        end
        tick();
        drive(1, 0, 0, 0, 10'd0, 8'h00);
        #1;
        n_cmp++;
        if (gnt !== 3'b001 || rvalid !== 3'b010 || rdata !== 8'h24) begin
            n_fail++;
            $display("FAIL t3_host_next: got gnt %b rv %b rdata %h want 001 010 24",
                     gnt, rvalid, rdata);
        end
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_write_then_read();
        int we_cnt = 0;
        do_reset();
        drive(0, 1, 0, 1, 10'd5, 8'hA5);
        #1;
        we_cnt += int'(ram_we);
        n_cmp++;
        if (gnt !== 3'b000) begin
            n_fail++; $display("FAIL t4_bubble: got %b want 000", gnt);
        end
        tick();
        we_cnt += int'(ram_we);
        n_cmp++;
        if (gnt !== 3'b001 || ram_we !== 1'b1 || ram_addr !== 10'd5 ||
            ram_wdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL t4_write: got gnt %b we %b addr %0d wd %h want 001 1 5 a5",
                     gnt, ram_we, ram_addr, ram_wdata);
        end
        tick();
        idle_all();
        drive(1, 1, 0, 0, 10'd5, 8'h00);
        #1;
        we_cnt += int'(ram_we);
        n_cmp++;
        if (gnt !== 3'b000 || rvalid !== 3'b000) begin
            n_fail++;
            $display("FAIL t4_handover: got gnt %b rv %b want 000 000", gnt, rvalid);
        end
        tick();
        we_cnt += int'(ram_we);
        n_cmp++;
        if (gnt !== 3'b010 || ram_we !== 1'b0 || ram_addr !== 10'd5) begin
            n_fail++;
            $display("FAIL t4_read: got gnt %b we %b addr %0d want 010 0 5",
                     gnt, ram_we, ram_addr);
        end
        tick();
        idle_all();
        #1;
        we_cnt += int'(ram_we);
        n_cmp++;
        if (rvalid !== 3'b010 || rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL t4_rdata: got rv %b rdata %h want 010 a5", rvalid, rdata);
        end
        n_cmp++;
        if (we_cnt !== 1) begin
            n_fail++; $display("FAIL t4_we_count: got %0d want 1", we_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drive(1, 1, 1, 0, 10'd100, 8'h00);
        tick();
        tick();
        drive(1, 1, 1, 0, 10'd101, 8'h00);
        #1;
        n_cmp++;
        if (gnt !== 3'b010 || rvalid !== 3'b010) begin
            n_fail++;
            $display("FAIL t5_pre: got gnt %b rv %b want 010 010", gnt, rvalid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 3'b000 || ram_en !== 1'b0 || rvalid !== 3'b000 ||
            ram_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL t5_async: got gnt %b en %b rv %b addr %0d want all 0",
                     gnt, ram_en, rvalid, ram_addr);
        end
        tick();
        idle_all();
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (rvalid !== 3'b000 || gnt !== 3'b000) begin
                n_fail++;
                $display("FAIL t5_after c%0d: got rv %b gnt %b want 000 000",
                         c, rvalid, gnt);
            end
        end
    endtask

    task automatic test_lock_timeout();
        logic [2:0] g5;
        logic       t5;
`ifdef ARB_LOCK_TIMEOUT_EN
        g5 = 3'b100;
        t5 = 1'b1;
`else
        g5 = 3'b010;
        t5 = 1'b0;
`endif
        do_reset();
        drive(1, 1, 1, 0, 10'd200, 8'h00);
        drive(2, 1, 0, 0, 10'd300, 8'h00);
        for (int c = 0; c < 7; c++) begin
            if (c > 0) tick();
            #1;
            if (c < 6) begin
                n_cmp++;
                if (gnt !== ((c == 0) ? 3'b000 : (c == 5) ? g5 : 3'b010)) begin
                    n_fail++;
                    $display("FAIL t6_gnt c%0d: got %b want %b", c, gnt,
                             (c == 0) ? 3'b000 : (c == 5) ? g5 : 3'b010);
                end
            end
            n_cmp++;
            if (lock_timeout !== ((c == 5) ? t5 : 1'b0)) begin
                n_fail++;
                $display("FAIL t6_timeout c%0d: got %b want %b", c, lock_timeout,
                         (c == 5) ? t5 : 1'b0);
            end
        end
        idle_all();
        tick();
    endtask

    initial begin
        idle_all();
        rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_write_then_read();
        test_reset_mid_burst();
        test_lock_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
